useq_ng: RTL and testbench
==========================

Name: useq_ng

Overview:
- Parametrised next-generation microsequencer core for the KS10 CPU.
- Forms the next control-ROM address from the J field, dispatch bits, skip bits and a call/return stack; forces the reset and trap addresses.
- Compared with the current sequencer, it adds:
  - configurable address width and stack depth;
  - stack overflow/underflow detection;
  - a microcode loop counter;
  - halt/single-step control for console debugging.
- Sits between the dispatch/skip logic and the synchronous CROM.

Parameters:
- AW, 12, microcode address width.
- SDEPTH, 8, call/return stack depth (power of two, 2..64).
- RESET_ADDR, 0, address forced after reset.
- TRAP_ADDR, 2**AW-1, page-fail trap address.
- CNTW, 8, loop counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clken  in  1  clock enable; all state changes only when clken=1
- trap  in  1  page fail; forces TRAP_ADDR and implies call
- j  in  AW  CROM J field
- disp_addr  in  AW  dispatch mux output
- skip_addr  in  AW  skip logic output
- call  in  1  CROM call bit
- ret  in  1  decoded return dispatch
- ld_cnt  in  1  load loop counter
- dec_cnt  in  1  decrement loop counter
- cnt_val  in  CNTW  loop counter load value
- halt_req  in  1  console halt request
- run  in  1  console resume
- step  in  1  single-step while halted
- clr_err  in  1  clear sticky stack flags
- addr  out  AW  next CROM address (combinational)
- cur_addr  out  AW  address of the executing microword (registered)
- tos  out  AW  stack top
- sp  out  log2(SDEPTH)+1  stack entry count
- halted  out  1  sequencer halted
- stk_ovf  out  1  sticky overflow
- stk_unf  out  1  sticky underflow
- cnt_zero  out  1  loop counter == 0

Behaviour:
- Reset (rst=1, async): the following take these values.
  - rst_pend=1, cur_addr=RESET_ADDR, sp=0, halted=0, stk_ovf=0, stk_unf=0, cnt=0, cnt_zero=1.
  - Stack RAM contents are don't-care.
  - rst_pend clears on the first clken after rst negates.
  - Reset mid-operation abandons all state immediately.
- Advance condition: adv = clken & (!halted | step).
- addr priority (combinational):
  1. rst_pend → RESET_ADDR.
  2. halted & !step → cur_addr (hold).
  3. trap → TRAP_ADDR.
  4. Otherwise (ret ? tos : disp_addr) | skip_addr | j.
- On adv: cur_addr <= addr.
- Push: eff_call = (call | trap) & !rst_pend. On adv & eff_call, push addr.
- Pop: eff_ret = ret & !trap & !rst_pend. On adv & eff_ret, pop.
- Push and pop together: overwrite the top entry with addr; sp unchanged.
- Full push (sp==SDEPTH): stk_ovf<=1, sp stays SDEPTH, circular write discards the oldest entry.
- Empty pop (sp==0): stk_unf<=1, sp stays 0, tos reads RESET_ADDR.
- tos reads RESET_ADDR whenever sp==0.
- Sticky flags: clr_err&clken clears both. A set event in the same cycle wins.
- Loop counter (on clken, independent of halt):
  - ld_cnt loads cnt_val.
  - else dec_cnt decrements, saturating at 0.
  - ld_cnt has priority over dec_cnt.
- Halt control (on clken):
  - halt_req sets halted; halt_req has priority over run.
  - The cycle in which halt_req is sampled still advances.
  - run clears halted.
  - step while halted advances exactly one microword per clken cycle with step=1, including stack effects.
- While halted & !step:
  - trap is ignored (no push, no address change);
  - call/ret have no effect.
- rst_pend=1 and halt_req together: halted sets, addr stays RESET_ADDR.

Test Plan:
- Reset release: assert rst 3 cycles, clken=1, j=0o123 → addr=0 during first post-reset clken, then 0o123; cur_addr=0o123 after the second edge.
- Call/return round trip:
  - Call with j=0o200 pushes 0o200, sp=1.
  - Later ret with skip_addr=1, j=0 → addr=0o201, sp=0.
- Overflow/underflow (SDEPTH=8):
  - 9 pushes → stk_ovf=1, sp=8, tos=last pushed.
  - 9 pops → stk_unf=1, sp=0, tos=RESET_ADDR.
  - clr_err → both flags 0.
- Trap precedence: trap=1 with ret=1 and disp_addr=0o40 → addr=0o7777, push of 0o7777, no pop, sp+1.
- Halt/step:
  - halt_req at cur_addr=0o100 → halted=1, addr holds 0o101 for 10 clken cycles; trap pulse ignored.
  - step → advances once.
  - run → free-running resumes.
- Loop counter:
  - ld_cnt with cnt_val=3, then 4 dec_cnt → cnt_zero=0,0,1,1.
  - ld_cnt and dec_cnt together → value loaded.

Source files
------------

// File: rtl/useq_ng.sv
// useq_ng: next-generation KS10 microsequencer core.
// Builds the next CROM address from the J field, the dispatch and skip inputs,
// and a call/return stack. It forces the reset and page-fail trap addresses,
// keeps a microcode loop counter, and gives console halt/single-step control.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   clken           clock enable; no state changes unless clken=1
//   trap            page fail: forces TRAP_ADDR and implies a call
//   j               CROM J field
//   disp_addr       dispatch mux output
//   skip_addr       skip logic output
//   call            CROM call bit
//   ret             decoded return dispatch
//   ld_cnt          load the loop counter
//   dec_cnt         decrement the loop counter
//   cnt_val         loop counter load value
//   halt_req        console halt request
//   run             console resume
//   step            single step while halted
//   clr_err         clear the sticky stack flags
//   addr            next CROM address (combinational)
//   cur_addr        address of the executing microword
//   tos             top of stack (RESET_ADDR when the stack is empty)
//   sp              stack entry count
//   halted          sequencer halted
//   stk_ovf         sticky stack overflow
//   stk_unf         sticky stack underflow
//   cnt_zero        loop counter is zero
module useq_ng #(
    parameter int unsigned     AW         = 12,
    parameter int unsigned     SDEPTH     = 8,
    parameter logic [AW-1:0]   RESET_ADDR = '0,
    parameter logic [AW-1:0]   TRAP_ADDR  = {AW{1'b1}},
    parameter int unsigned     CNTW       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clken,
    input  logic                     trap,
    input  logic [AW-1:0]            j,
    input  logic [AW-1:0]            disp_addr,
    input  logic [AW-1:0]            skip_addr,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     ld_cnt,
    input  logic                     dec_cnt,
    input  logic [CNTW-1:0]          cnt_val,
    input  logic                     halt_req,
    input  logic                     run,
    input  logic                     step,
    input  logic                     clr_err,
    output logic [AW-1:0]            addr,
    output logic [AW-1:0]            cur_addr,
    output logic [AW-1:0]            tos,
    output logic [$clog2(SDEPTH):0]  sp,
    output logic                     halted,
    output logic                     stk_ovf,
    output logic                     stk_unf,
    output logic                     cnt_zero
);

    localparam int unsigned IW  = $clog2(SDEPTH);
    localparam int unsigned SPW = IW + 1;

    // The reset-pending, running and halted modes are mutually exclusive.
    typedef enum logic [1:0] {
        S_RST,
        S_RUN,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rst_pend;
    logic            hold;
    logic            adv;
    logic            do_push;
    logic            do_pop;

    logic [AW-1:0]   mem [SDEPTH];
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_nxt;
    logic [IW-1:0]   top_idx;
    logic [IW-1:0]   wr_idx;
    logic            wr_en;
    logic [SPW-1:0]  sp_nxt;
    logic            full;
    logic            empty;
    logic            ovf_set;
    logic            unf_set;

    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;

    assign rst_pend = (state == S_RST);
    assign halted   = (state == S_HALT);
    assign hold     = halted & ~step;
    assign adv      = clken & ~hold;

    // A trap implies a call and suppresses any return in the same microword.
    assign do_push  = adv & (call | trap) & ~rst_pend;
    assign do_pop   = adv & ret & ~trap & ~rst_pend;

    // ptr is the next free slot; the top entry sits one below it (mod SDEPTH).
    assign top_idx  = ptr - IW'(1);
    assign full     = (sp == SPW'(SDEPTH));
    assign empty    = (sp == '0);
    assign tos      = empty ? RESET_ADDR : mem[top_idx];

    // Halt mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt mode next state: halt_req beats run, and the reset-pending state
    // always leaves on the first enabled cycle.
    always_comb begin
        state_nxt = state;
        if (clken) begin
            if (halt_req) begin
                state_nxt = S_HALT;
            end else if (state == S_RST) begin
                state_nxt = S_RUN;
            end else if (state == S_HALT && run) begin
                state_nxt = S_RUN;
            end
        end
    end

    // Next address select.
    always_comb begin
        addr = RESET_ADDR;
        if (rst_pend) begin
            addr = RESET_ADDR;
        end else if (hold) begin
            addr = cur_addr;
        end else if (trap) begin
            addr = TRAP_ADDR;
        end else begin
            addr = (ret ? tos : disp_addr) | skip_addr | j;
        end
    end

    // Stack next state. A push on a full stack overwrites the oldest slot
    // because ptr then points at it. A push together with a pop replaces the top.
    always_comb begin
        sp_nxt  = sp;
        ptr_nxt = ptr;
        wr_en   = 1'b0;
        wr_idx  = ptr;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (do_push && do_pop) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (do_push) begin
            wr_en   = 1'b1;
            wr_idx  = ptr;
            ptr_nxt = ptr + IW'(1);
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                sp_nxt = sp + SPW'(1);
            end
        end else if (do_pop) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                ptr_nxt = top_idx;
                sp_nxt  = sp - SPW'(1);
            end
        end
    end

    // Loop counter next state; ld_cnt wins, and decrement saturates at zero.
    always_comb begin
        cnt_nxt = cnt;
        if (clken) begin
            if (ld_cnt) begin
                cnt_nxt = cnt_val;
            end else if (dec_cnt && cnt != '0) begin
                cnt_nxt = cnt - CNTW'(1);
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= RESET_ADDR;
            sp       <= '0;
            ptr      <= '0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
            cnt      <= '0;
            cnt_zero <= 1'b1;
        end else begin
            if (adv) begin
                cur_addr <= addr;
            end
            sp       <= sp_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            cnt_zero <= (cnt_nxt == '0);
            // A flag that is set in the same cycle overrides clr_err.
            if (ovf_set) begin
                stk_ovf <= 1'b1;
            end else if (clr_err && clken) begin
                stk_ovf <= 1'b0;
            end
            if (unf_set) begin
                stk_unf <= 1'b1;
            end else if (clr_err && clken) begin
                stk_unf <= 1'b0;
            end
        end
    end

    // Stack storage; the contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= addr;
        end
    end

endmodule

// File: tb/tb_useq_ng.sv
// tb_useq_ng: directed scoreboard bench for useq_ng.
// The stimulus drives inputs just after each rising edge and queues the
// outputs it expects for that cycle. The monitor pops one entry each falling
// edge and compares it with the DUT.
module tb_useq_ng;

    logic        clk = 1'b0;
    logic        rst;
    logic        clken;
    logic        trap;
    logic [11:0] j;
    logic [11:0] disp_addr;
    logic [11:0] skip_addr;
    logic        call;
    logic        ret;
    logic        ld_cnt;
    logic        dec_cnt;
    logic [7:0]  cnt_val;
    logic        halt_req;
    logic        run;
    logic        step;
    logic        clr_err;
    logic [11:0] addr;
    logic [11:0] cur_addr;
    logic [11:0] tos;
    logic [3:0]  sp;
    logic        halted;
    logic        stk_ovf;
    logic        stk_unf;
    logic        cnt_zero;

    int total = 0;
    int bad   = 0;

    // A field set to -1 is not checked.
    typedef struct {
        string name;
        int    addr;
        int    cur;
        int    tos;
        int    sp;
        int    hlt;
        int    ovf;
        int    unf;
        int    cz;
    } exp_t;

    exp_t q[$];
    exp_t e;

    useq_ng dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .trap      (trap),
        .j         (j),
        .disp_addr (disp_addr),
        .skip_addr (skip_addr),
        .call      (call),
        .ret       (ret),
        .ld_cnt    (ld_cnt),
        .dec_cnt   (dec_cnt),
        .cnt_val   (cnt_val),
        .halt_req  (halt_req),
        .run       (run),
        .step      (step),
        .clr_err   (clr_err),
        .addr      (addr),
        .cur_addr  (cur_addr),
        .tos       (tos),
        .sp        (sp),
        .halted    (halted),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf),
        .cnt_zero  (cnt_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t nx(input string n);
        exp_t r;
        r.name = n;
        r.addr = -1; r.cur = -1; r.tos = -1; r.sp = -1;
        r.hlt  = -1; r.ovf = -1; r.unf = -1; r.cz = -1;
        return r;
    endfunction

    task automatic chk(input string n, input string f, input int act, input int expv);
        if (expv >= 0) begin
            total++;
            if (act != expv) begin
                bad++;
                $display("FAIL %s.%s actual=%0o expected=%0o", n, f, act, expv);
            end
        end
    endtask

    // Monitor: compare the queued expectation against the settled outputs.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                m = q.pop_front();
                chk(m.name, "addr",     int'(addr),     m.addr);
                chk(m.name, "cur_addr", int'(cur_addr), m.cur);
                chk(m.name, "tos",      int'(tos),      m.tos);
                chk(m.name, "sp",       int'(sp),       m.sp);
                chk(m.name, "halted",   int'(halted),   m.hlt);
                chk(m.name, "stk_ovf",  int'(stk_ovf),  m.ovf);
                chk(m.name, "stk_unf",  int'(stk_unf),  m.unf);
                chk(m.name, "cnt_zero", int'(cnt_zero), m.cz);
            end
        end
    end

    // Wait for the next cycle and return the inputs to an idle pattern.
    task automatic tick();
        @(posedge clk);
        #1;
        clken = 1'b1; trap = 1'b0; j = '0; disp_addr = '0; skip_addr = '0;
        call = 1'b0; ret = 1'b0; ld_cnt = 1'b0; dec_cnt = 1'b0; cnt_val = '0;
        halt_req = 1'b0; run = 1'b0; step = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clken = 1'b1; trap = 1'b0; j = 12'o123; disp_addr = '0;
        skip_addr = '0; call = 1'b0; ret = 1'b0; ld_cnt = 1'b0; dec_cnt = 1'b0;
        cnt_val = '0; halt_req = 1'b0; run = 1'b0; step = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state.
        tick(); j = 12'o123;
        e = nx("reset"); e.addr = 0; e.cur = 0; e.tos = 0; e.sp = 0; e.hlt = 0;
        e.ovf = 0; e.unf = 0; e.cz = 1; q.push_back(e);

        // Reset release: RESET_ADDR on the first enabled cycle, then J.
        tick(); rst = 1'b0; j = 12'o123;
        e = nx("rel0"); e.addr = 0; e.cur = 0; q.push_back(e);
        tick(); j = 12'o123;
        e = nx("rel1"); e.addr = 12'o123; e.cur = 0; q.push_back(e);
        tick(); j = 12'o123;
        e = nx("rel2"); e.addr = 12'o123; e.cur = 12'o123; q.push_back(e);

        // Call and return round trip.
        tick(); j = 12'o200; call = 1'b1;
        e = nx("call"); e.addr = 12'o200; e.sp = 0; q.push_back(e);
        tick(); j = 12'o300;
        e = nx("called"); e.addr = 12'o300; e.sp = 1; e.tos = 12'o200; e.cur = 12'o200; q.push_back(e);
        tick(); ret = 1'b1; skip_addr = 12'o1;
        e = nx("ret"); e.addr = 12'o201; e.sp = 1; q.push_back(e);
        tick();
        e = nx("retd"); e.addr = 0; e.sp = 0; e.tos = 0; e.cur = 12'o201; q.push_back(e);

        // Nine pushes into an eight-deep stack.
        for (int i = 1; i <= 9; i++) begin
            tick(); j = 12'(i); call = 1'b1;
            e = nx($sformatf("push%0d", i)); e.addr = i; e.sp = (i > 8) ? 8 : i - 1;
            e.ovf = 0; q.push_back(e);
        end
        tick();
        e = nx("full"); e.sp = 8; e.ovf = 1; e.unf = 0; e.tos = 9; q.push_back(e);

        // Nine pops; the oldest entry (1) was lost to the wrap.
        for (int k = 0; k < 9; k++) begin
            tick(); ret = 1'b1;
            e = nx($sformatf("pop%0d", k)); e.sp = 8 - k; e.tos = (k < 8) ? 9 - k : 0;
            e.addr = e.tos; e.unf = 0; q.push_back(e);
        end
        tick();
        e = nx("empty"); e.sp = 0; e.unf = 1; e.ovf = 1; e.tos = 0; q.push_back(e);
        tick(); clr_err = 1'b1;
        e = nx("clr0"); e.ovf = 1; e.unf = 1; q.push_back(e);
        tick();
        e = nx("clr1"); e.ovf = 0; e.unf = 0; q.push_back(e);

        // Trap beats return: pushes TRAP_ADDR and does not pop.
        tick(); trap = 1'b1; ret = 1'b1; disp_addr = 12'o40;
        e = nx("trap"); e.addr = 12'o7777; e.sp = 0; q.push_back(e);
        tick();
        e = nx("trapd"); e.sp = 1; e.tos = 12'o7777; e.cur = 12'o7777; e.unf = 0; q.push_back(e);
        tick(); ret = 1'b1;
        e = nx("trapret"); e.addr = 12'o7777; e.sp = 1; q.push_back(e);

        // Halt with the sampling cycle still advancing.
        tick(); j = 12'o100;
        e = nx("pre_halt"); e.sp = 0; e.addr = 12'o100; q.push_back(e);
        tick(); j = 12'o101; halt_req = 1'b1;
        e = nx("halt_req"); e.cur = 12'o100; e.addr = 12'o101; e.hlt = 0; q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            tick(); j = 12'o777; trap = (i == 4); call = (i == 6);
            e = nx($sformatf("hold%0d", i)); e.addr = 12'o101; e.cur = 12'o101;
            e.hlt = 1; e.sp = 0; q.push_back(e);
        end
        tick(); step = 1'b1; call = 1'b1; j = 12'o110;
        e = nx("step"); e.addr = 12'o110; e.hlt = 1; e.sp = 0; q.push_back(e);
        tick(); j = 12'o120;
        e = nx("stepd"); e.addr = 12'o110; e.cur = 12'o110; e.hlt = 1; e.sp = 1; e.tos = 12'o110; q.push_back(e);
        tick(); run = 1'b1; j = 12'o120;
        e = nx("run"); e.addr = 12'o110; e.hlt = 1; q.push_back(e);
        tick(); j = 12'o120;
        e = nx("running"); e.addr = 12'o120; e.cur = 12'o110; e.hlt = 0; q.push_back(e);
        tick(); j = 12'o130;
        e = nx("running2"); e.addr = 12'o130; e.cur = 12'o120; q.push_back(e);

        // Loop counter load, decrements with saturation, load priority.
        tick(); ld_cnt = 1'b1; cnt_val = 8'd3;
        e = nx("ld3"); e.cz = 1; q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            tick(); dec_cnt = 1'b1;
            e = nx($sformatf("dec%0d", i)); e.cz = (i == 3) ? 1 : 0; q.push_back(e);
        end
        tick();
        e = nx("sat"); e.cz = 1; q.push_back(e);
        tick(); ld_cnt = 1'b1; dec_cnt = 1'b1; cnt_val = 8'd1;
        e = nx("lddec"); e.cz = 1; q.push_back(e);
        tick();
        e = nx("lddecd"); e.cz = 0; e.cur = 0; q.push_back(e);

        // clken low freezes every register.
        tick(); clken = 1'b0; ld_cnt = 1'b1; cnt_val = 8'd0; j = 12'o555; clr_err = 1'b1;
        e = nx("noclk"); e.addr = 12'o555; e.cur = 0; q.push_back(e);
        tick();
        e = nx("noclkd"); e.cur = 0; e.cz = 0; e.sp = 1; q.push_back(e);

        // Asynchronous reset mid-operation, then reset-pending with halt_req.
        tick(); rst = 1'b1;
        e = nx("rst_mid"); e.sp = 0; e.cur = 0; e.hlt = 0; e.cz = 1; e.addr = 0; q.push_back(e);
        tick(); rst = 1'b0; halt_req = 1'b1; j = 12'o321;
        e = nx("rst_halt"); e.addr = 0; e.hlt = 0; q.push_back(e);
        tick(); j = 12'o321;
        e = nx("rst_halted"); e.addr = 0; e.cur = 0; e.hlt = 1; q.push_back(e);

        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
